dac_spi_rx: RTL and testbench

Serial receiver for the dual-DAC SPI bus: the far end of the DAC transmitter link. It oversamples SCLK, the two active-low chip selects and the data line with the system clock. It decodes the 16-bit DAC frames and rebuilds the 32-bit four-channel word that was sent. It sits on the board-test/loopback path, so firmware can check what actually went out on the DAC pins and raise sticky protocol errors.

---
 rtl/dac_spi_rx.sv | 156 +++++++++++++++
 tb/tb_dac_spi_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dac_spi_rx.sv
// rtl/dac_spi_rx.sv - loopback receiver for the dual-DAC SPI bus
// Rebuilds per-channel bytes and the 4-channel word, flags sticky protocol errors.
module dac_spi_rx (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ClkDac,
  input  logic [1:0]  i_CsDac,
  input  logic        i_dataDac,
  input  logic        i_err_clr,
  output logic [31:0] o_ch_data,
  output logic [3:0]  o_ch_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic [3:0]  o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COLLIDE} state_t;

  state_t      state, state_nx;
  logic [1:0]  sclk_sync;
  logic        sclk_q;
  logic [1:0]  cs_m, cs_s, cs_q;
  logic [1:0]  dat_sync;
  logic        pair_a;
  logic [15:0] sr;
  logic [4:0]  bit_cnt;
  logic [3:0]  mask;

  logic        sclk_rise;
  logic [1:0]  cs_fall, cs_rise;
  logic        act_rise, other_fall;
  logic        len_ok, ctrl_ok, fill_ok;
  logic [1:0]  ch;
  logic        start, shift_en, commit;
  logic [3:0]  err_set;

  // CS synchronizers reset to "asserted" so a CS already low at reset release
  // produces no falling edge and is ignored until it cycles high again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync <= 2'b00;
      sclk_q    <= 1'b0;
      cs_m      <= 2'b00;
      cs_s      <= 2'b00;
      cs_q      <= 2'b00;
      dat_sync  <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[0], i_ClkDac};
      sclk_q    <= sclk_sync[1];
      cs_m      <= i_CsDac;
      cs_s      <= cs_m;
      cs_q      <= cs_s;
      dat_sync  <= {dat_sync[0], i_dataDac};
    end
  end

  assign sclk_rise  = sclk_sync[1] & ~sclk_q;
  assign cs_fall    = ~cs_s & cs_q;
  assign cs_rise    = cs_s & ~cs_q;
  assign act_rise   = pair_a ? cs_rise[1] : cs_rise[0];
  assign other_fall = pair_a ? cs_fall[0] : cs_fall[1];

  assign len_ok  = (bit_cnt == 5'd16);
  assign ctrl_ok = (sr[15:12] == 4'b0111) || (sr[15:12] == 4'b1111);
  assign fill_ok = (sr[3:0] == 4'b0011);
  assign ch      = {~pair_a, sr[15]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    err_set  = 4'b0000;
    case (state)
      IDLE: begin
        if (cs_fall == 2'b01 || cs_fall == 2'b10) begin
          start    = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = sclk_rise;
        if (other_fall) begin
          err_set[1] = 1'b1;
          state_nx   = COLLIDE;
        end else if (act_rise) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        // Nibble checks are meaningless on a misaligned frame, so only length is reported then.
        if (!len_ok) begin
          err_set[0] = 1'b1;
        end else begin
          err_set[2] = ~ctrl_ok;
          err_set[3] = ~fill_ok;
        end
        commit   = len_ok & ctrl_ok & fill_ok;
        state_nx = IDLE;
      end
      COLLIDE: begin
        if (cs_s == 2'b11) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pair_a       <= 1'b0;
      sr           <= 16'h0000;
      bit_cnt      <= 5'd0;
      mask         <= 4'b0000;
      o_ch_data    <= 32'h0;
      o_ch_valid   <= 4'b0000;
      o_word       <= 32'h0;
      o_word_valid <= 1'b0;
      o_err        <= 4'b0000;
    end else begin
      o_ch_valid   <= 4'b0000;
      o_word_valid <= 1'b0;
      o_err        <= (i_err_clr ? 4'b0000 : o_err) | err_set;
      if (start) begin
        pair_a  <= cs_fall[1];
        sr      <= 16'h0000;
        bit_cnt <= 5'd0;
      end else if (shift_en) begin
        sr <= {sr[14:0], dat_sync[1]};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (commit) begin
        o_ch_data[{ch, 3'b000} +: 8] <= sr[11:4];
        o_ch_valid[ch]               <= 1'b1;
        // ch3 closes a set: publish the word only if ch0..ch2 arrived since the last close.
        if (ch == 2'd3) begin
          mask <= 4'b0000;
          if (mask[2:0] == 3'b111) begin
            o_word       <= {sr[11:4], o_ch_data[23:0]};
            o_word_valid <= 1'b1;
          end
        end else begin
          mask[ch] <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (state == SHIFT);

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb/tb_dac_spi_rx.sv - directed self-checking bench for dac_spi_rx
module tb_dac_spi_rx;

  logic        clk = 1'b0;
  logic        rst, sclk, dat, err_clr;
  logic [1:0]  cs;
  logic [31:0] o_ch_data, o_word;
  logic [3:0]  o_ch_valid, o_err;
  logic        o_word_valid, o_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_raise = 0;
  int v_cyc = 0;
  int vcnt[4] = '{0, 0, 0, 0};
  int wcnt = 0;
  logic        w_with_v3 = 1'b0;
  logic [31:0] w_val = 32'h0;

  dac_spi_rx dut (
    .i_clk(clk), .i_rst(rst), .i_ClkDac(sclk), .i_CsDac(cs), .i_dataDac(dat),
    .i_err_clr(err_clr), .o_ch_data(o_ch_data), .o_ch_valid(o_ch_valid),
    .o_word(o_word), .o_word_valid(o_word_valid), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: tasks compare deltas of these counters against expectations.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      if (o_ch_valid[k]) begin vcnt[k] = vcnt[k] + 1; v_cyc = cyc; end
    if (o_word_valid) begin wcnt = wcnt + 1; w_with_v3 = o_ch_valid[3]; w_val = o_word; end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    dat = b; wait_clk(16); sclk = 1'b1; wait_clk(16); sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] cs_low, input logic [15:0] w, input int nbits, input bit clr_at_check);
    cs = cs_low; wait_clk(16);
    for (int i = 15; i > 15 - nbits; i--) spi_bit(w[i]);
    wait_clk(16); cs = 2'b11; t_raise = cyc;
    if (clr_at_check) begin wait_clk(3); err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(6); end
    else wait_clk(10);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; wait_clk(1); err_clr = 1'b0; wait_clk(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(3);
    total++; if (o_ch_data !== 32'h0) begin $display("FAIL rst_ch_data got=%h exp=0", o_ch_data); bad++; end
    total++; if (o_word !== 32'h0) begin $display("FAIL rst_word got=%h exp=0", o_word); bad++; end
    total++; if ({o_ch_valid, o_word_valid, o_err, o_busy} !== 10'h0) begin
      $display("FAIL rst_flags got=%b exp=0", {o_ch_valid, o_word_valid, o_err, o_busy}); bad++; end
    rst = 1'b0; wait_clk(5);
  endtask

  task automatic test_four_channels();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int vb[4];
    int wb;
    wb = wcnt;
    for (int i = 0; i < 4; i++) begin
      vb = vcnt;
      send_frame((i < 2) ? 2'b01 : 2'b10, {((i % 2) == 1) ? 4'b1111 : 4'b0111, bytes[i], 4'b0011}, 16, 1'b0);
      total++; if (vcnt[i] - vb[i] !== 1) begin $display("FAIL ch%0d_valid got=%0d exp=1", i, vcnt[i] - vb[i]); bad++; end
      total++; if (o_ch_data[i*8 +: 8] !== bytes[i]) begin
        $display("FAIL ch%0d_data got=%h exp=%h", i, o_ch_data[i*8 +: 8], bytes[i]); bad++; end
      total++; if (v_cyc - t_raise !== 4) begin $display("FAIL ch%0d_latency got=%0d exp=4", i, v_cyc - t_raise); bad++; end
    end
    total++; if (wcnt - wb !== 1) begin $display("FAIL word_valid_count got=%0d exp=1", wcnt - wb); bad++; end
    total++; if (w_val !== 32'h44332211) begin $display("FAIL word_value got=%h exp=44332211", w_val); bad++; end
    total++; if (w_with_v3 !== 1'b1) begin $display("FAIL word_with_ch3 got=%b exp=1", w_with_v3); bad++; end
    total++; if (o_err !== 4'b0000) begin $display("FAIL four_ch_err got=%b exp=0000", o_err); bad++; end
  endtask

  task automatic test_length_error();
    int vb[4];
    vb = vcnt;
    send_frame(2'b01, {4'b0111, 8'h99, 4'b0011}, 15, 1'b0);
    total++; if (o_err !== 4'b0001) begin $display("FAIL len_err got=%b exp=0001", o_err); bad++; end
    total++; if (vcnt !== vb) begin $display("FAIL len_no_valid got=%0d exp=%0d", vcnt[0] + vcnt[1], vb[0] + vb[1]); bad++; end
    total++; if (o_ch_data !== 32'h44332211) begin $display("FAIL len_data got=%h exp=44332211", o_ch_data); bad++; end
    pulse_clr();
    total++; if (o_err !== 4'b0000) begin $display("FAIL len_clr got=%b exp=0000", o_err); bad++; end
  endtask

  task automatic test_collision();
    logic [15:0] w = {4'b0111, 8'h66, 4'b0011};
    int vb[4];
    vb = vcnt;
    cs = 2'b01; wait_clk(16);
    for (int i = 15; i > 7; i--) spi_bit(w[i]);
    cs = 2'b00; wait_clk(5);
    total++; if (o_err !== 4'b0010) begin $display("FAIL coll_err got=%b exp=0010", o_err); bad++; end
    for (int i = 7; i >= 0; i--) spi_bit(w[i]);
    wait_clk(16); cs = 2'b10; wait_clk(10);
    total++; if (vcnt !== vb || o_busy !== 1'b0) begin
      $display("FAIL coll_hold got busy=%b valid_delta=%0d exp busy=0 delta=0", o_busy, vcnt[1] - vb[1]); bad++; end
    cs = 2'b11; wait_clk(10);
    total++; if (vcnt !== vb) begin $display("FAIL coll_no_update got=%0d exp=%0d", vcnt[1], vb[1]); bad++; end
    pulse_clr();
    send_frame(2'b01, {4'b1111, 8'h5A, 4'b0011}, 16, 1'b0);
    total++; if (vcnt[1] - vb[1] !== 1) begin $display("FAIL coll_next_valid got=%0d exp=1", vcnt[1] - vb[1]); bad++; end
    total++; if (o_ch_data !== 32'h44335A11) begin $display("FAIL coll_next_data got=%h exp=44335a11", o_ch_data); bad++; end
    total++; if (o_err !== 4'b0000) begin $display("FAIL coll_next_err got=%b exp=0000", o_err); bad++; end
  endtask

  task automatic test_bad_nibbles();
    int vb[4];
    vb = vcnt;
    send_frame(2'b10, {4'b0101, 8'h77, 4'b0000}, 16, 1'b0);
    total++; if (o_err !== 4'b1100) begin $display("FAIL nib_err got=%b exp=1100", o_err); bad++; end
    total++; if (vcnt !== vb) begin $display("FAIL nib_no_valid got=%0d exp=%0d", vcnt[2], vb[2]); bad++; end
    total++; if (o_ch_data !== 32'h44335A11) begin $display("FAIL nib_data got=%h exp=44335a11", o_ch_data); bad++; end
    send_frame(2'b01, {4'b0111, 8'h12, 4'b0011}, 15, 1'b1);
    total++; if (o_err !== 4'b0001) begin $display("FAIL set_beats_clr got=%b exp=0001", o_err); bad++; end
    pulse_clr();
    total++; if (o_err !== 4'b0000) begin $display("FAIL nib_clr got=%b exp=0000", o_err); bad++; end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w = {4'b0111, 8'hC3, 4'b0011};
    int vb[4];
    int wb;
    vb = vcnt; wb = wcnt;
    cs = 2'b10; wait_clk(16);
    for (int i = 15; i > 7; i--) spi_bit(w[i]);
    total++; if (o_busy !== 1'b1) begin $display("FAIL mid_busy got=%b exp=1", o_busy); bad++; end
    rst = 1'b1; wait_clk(2);
    total++; if ({o_ch_data, o_word, o_err, o_busy, o_ch_valid, o_word_valid} !== 74'h0) begin
      $display("FAIL mid_rst_outs got data=%h word=%h err=%b busy=%b exp all 0", o_ch_data, o_word, o_err, o_busy); bad++; end
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(w[i]);
    wait_clk(16); cs = 2'b11; wait_clk(10);
    total++; if (vcnt !== vb || o_ch_data !== 32'h0) begin
      $display("FAIL mid_ignored got data=%h delta=%0d exp data=0 delta=0", o_ch_data, vcnt[2] - vb[2]); bad++; end
    send_frame(2'b10, {4'b1111, 8'hA5, 4'b0011}, 16, 1'b0);
    total++; if (vcnt[3] - vb[3] !== 1) begin $display("FAIL post_ch3_valid got=%0d exp=1", vcnt[3] - vb[3]); bad++; end
    total++; if (o_ch_data !== 32'hA5000000) begin $display("FAIL post_ch3_data got=%h exp=a5000000", o_ch_data); bad++; end
    total++; if (wcnt !== wb || o_word !== 32'h0) begin
      $display("FAIL post_no_word got cnt=%0d word=%h exp cnt=0 word=0", wcnt - wb, o_word); bad++; end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; dat = 1'b0; cs = 2'b11; err_clr = 1'b0;
    test_reset();
    test_four_channels();
    test_length_error();
    test_collision();
    test_bad_nibbles();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
